// File: rtl/delayed_sampler_pkg.sv
// Shared types and default constants for the delayed change sampler.
package delayed_sampler_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_B = 2'd1,
        WAIT_C = 2'd2
    } sampler_state_t;

    localparam int unsigned DEF_W  = 6;
    localparam int unsigned DEF_D1 = 10;
    localparam int unsigned DEF_D2 = 5;

endpackage

// File: rtl/delay_down_counter.sv
// Loadable down-counter used to time the two capture delays.
// zero is decoded from the registered count.
module delay_down_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q;

    // Load has priority over decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/delayed_change_sampler.sv
// Change-triggered two-stage sampler: a change on a_in starts a capture,
// b_out takes a_in D1 cycles later, c_out takes b_out D2 cycles after that.
// Changes seen while a capture is in flight are dropped and counted.
// Optional macro DELAYED_SAMPLER_PENDING_EN adds a 1-deep pending request
// that chains a new capture directly off the end of the current one.
module delayed_change_sampler
    import delayed_sampler_pkg::*;
#(
    parameter int unsigned W     = DEF_W,
    parameter int unsigned D1    = DEF_D1,
    parameter int unsigned D2    = DEF_D2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     a_in,
    output logic [W-1:0]     b_out,
    output logic [W-1:0]     c_out,
    output logic             busy,
    output logic             entry_pulse,
    output logic             exit_pulse,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int unsigned CNT_MAX = (D1 > D2) ? D1 : D2;
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] LOAD_B = CW'(D1 - 1);
    localparam logic [CW-1:0] LOAD_C = CW'(D2 - 1);

    sampler_state_t state_q, state_nxt;
    logic [W-1:0]   a_prev;
    logic           change_c;
    logic           cnt_zero_c;
    logic           cnt_load_c;
    logic [CW-1:0]  cnt_load_val_c;
    logic           cnt_en_c;
    logic           b_cap_c;
    logic           c_cap_c;
    logic           entry_nxt_c;
    logic           exit_nxt_c;
    logic           drop_inc_c;
`ifdef DELAYED_SAMPLER_PENDING_EN
    logic           pending_q;
    logic           pend_set_c;
    logic           pend_clr_c;
`endif

    assign change_c = (a_in != a_prev);

    delay_down_counter #(
        .WIDTH (CW)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_c),
        .load_val (cnt_load_val_c),
        .en       (cnt_en_c),
        .zero     (cnt_zero_c)
    );

    // Next-state, counter control and capture strobes.
    always_comb begin
        state_nxt      = state_q;
        cnt_load_c     = 1'b0;
        cnt_load_val_c = LOAD_B;
        cnt_en_c       = 1'b0;
        b_cap_c        = 1'b0;
        c_cap_c        = 1'b0;
        entry_nxt_c    = 1'b0;
        exit_nxt_c     = 1'b0;
        drop_inc_c     = 1'b0;
`ifdef DELAYED_SAMPLER_PENDING_EN
        pend_set_c     = 1'b0;
        pend_clr_c     = 1'b0;
`endif
        if (state_q != IDLE) begin
`ifdef DELAYED_SAMPLER_PENDING_EN
            drop_inc_c = change_c & pending_q;
            pend_set_c = change_c & ~pending_q;
`else
            drop_inc_c = change_c;
`endif
        end
        unique case (state_q)
            IDLE: begin
                if (change_c) begin
                    state_nxt   = WAIT_B;
                    cnt_load_c  = 1'b1;
                    entry_nxt_c = 1'b1;
                end
            end
            WAIT_B: begin
                if (cnt_zero_c) begin
                    b_cap_c        = 1'b1;
                    cnt_load_c     = 1'b1;
                    cnt_load_val_c = LOAD_C;
                    state_nxt      = WAIT_C;
                end else begin
                    cnt_en_c = 1'b1;
                end
            end
            WAIT_C: begin
                if (cnt_zero_c) begin
                    c_cap_c    = 1'b1;
                    exit_nxt_c = 1'b1;
                    state_nxt  = IDLE;
`ifdef DELAYED_SAMPLER_PENDING_EN
                    // A queued or same-edge change chains straight into a new capture.
                    if (pending_q || change_c) begin
                        state_nxt   = WAIT_B;
                        cnt_load_c  = 1'b1;
                        entry_nxt_c = 1'b1;
                        pend_clr_c  = 1'b1;
                    end
`endif
                end else begin
                    cnt_en_c = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, capture registers, pulses and saturating drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_prev      <= '0;
            b_out       <= '0;
            c_out       <= '0;
            busy        <= 1'b0;
            entry_pulse <= 1'b0;
            exit_pulse  <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            state_q     <= state_nxt;
            a_prev      <= a_in;
            busy        <= (state_nxt != IDLE);
            entry_pulse <= entry_nxt_c;
            exit_pulse  <= exit_nxt_c;
            if (b_cap_c) begin
                b_out <= a_in;
            end
            if (c_cap_c) begin
                c_out <= b_out;
            end
            if (drop_inc_c && (drop_cnt != {CNT_W{1'b1}})) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

`ifdef DELAYED_SAMPLER_PENDING_EN
    // Single-entry pending request; clearing wins over setting.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 1'b0;
        end else if (pend_clr_c) begin
            pending_q <= 1'b0;
        end else if (pend_set_c) begin
            pending_q <= 1'b1;
        end
    end
`endif

endmodule
